audio_sample_buffer: RTL and testbench

AUDIO_SAMPLE_BUFFER -- requirements
Module: audio_sample_buffer

---
 rtl/audio_sample_buffer.sv | 143 ++++++++++++++
 tb/tb_audio_sample_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_buffer.sv
// Audio sample block buffer: collects BUFFER_DEPTH samples, announces the full
// block with a one-cycle pulse, then drains it in arrival order to a consumer.
module audio_sample_buffer #(
  parameter int unsigned BUFFER_DEPTH = 16,
  parameter int unsigned DATA_WIDTH   = 24
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic signed [DATA_WIDTH-1:0] sample_data_i,
  input  logic                         sample_valid_i,
  output logic                         sample_ready_o,
  output logic signed [DATA_WIDTH-1:0] ram_read_data_o,
  output logic                         ram_read_valid_o,
  input  logic                         ram_read_ready_i,
  output logic                         ram_buffer_ready_o,
  output logic                         overflow_o,
  output logic [7:0]                   drop_count_o,
  output logic [5:0]                   debug_o
);

  localparam int unsigned AW = $clog2(BUFFER_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    ST_FILL     = 2'd0,
    ST_ANNOUNCE = 2'd1,
    ST_DRAIN    = 2'd2
  } state_t;

  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_mem [BUFFER_DEPTH];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [PW-1:0]           r_count;
  logic                    r_sample_ready;
  logic                    r_read_valid;
  logic                    r_buf_ready;
  logic [DATA_WIDTH-1:0]   r_read_data;
  logic                    r_overflow;
  logic [7:0]              r_drop_count;

  logic w_rd_hs;
  logic w_wr_en;
  logic w_drop;
  logic w_fill_last;
  logic w_drain_last;

  // Handshake and event decode; the write pointer MSB guards against writing past a full block
  assign w_rd_hs      = r_read_valid & ram_read_ready_i;
  assign w_wr_en      = (r_state == ST_FILL) & sample_valid_i & ~r_wr_ptr[PW-1];
  assign w_drop       = sample_valid_i & (r_state != ST_FILL);
  assign w_fill_last  = (r_count == PW'(BUFFER_DEPTH - 1));
  assign w_drain_last = (r_rd_ptr == PW'(BUFFER_DEPTH));

  // Sample storage, written only while filling; contents need no reset
  always_ff @(posedge clk_i) begin
    if (w_wr_en && !rst_i) begin
      r_mem[r_wr_ptr[AW-1:0]] <= sample_data_i;
    end
  end

  // Block FSM: fill, one-cycle announce, drain; rd_ptr always names the next entry to load
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= ST_FILL;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_sample_ready <= 1'b1;
      r_read_valid   <= 1'b0;
      r_buf_ready    <= 1'b0;
      r_read_data    <= '0;
    end else begin
      r_buf_ready <= 1'b0;
      case (r_state)
        ST_FILL: begin
          r_sample_ready <= 1'b1;
          if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
            r_count  <= r_count + PW'(1);
            if (w_fill_last) begin
              r_state        <= ST_ANNOUNCE;
              r_sample_ready <= 1'b0;
              r_buf_ready    <= 1'b1;
            end
          end
        end
        ST_ANNOUNCE: begin
          r_read_data  <= r_mem[r_rd_ptr[AW-1:0]];
          r_rd_ptr     <= r_rd_ptr + PW'(1);
          r_read_valid <= 1'b1;
          r_state      <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_rd_hs) begin
            if (w_drain_last) begin
              r_state        <= ST_FILL;
              r_read_valid   <= 1'b0;
              r_sample_ready <= 1'b1;
              r_wr_ptr       <= '0;
              r_rd_ptr       <= '0;
              r_count        <= '0;
            end else begin
              r_read_data <= r_mem[r_rd_ptr[AW-1:0]];
              r_rd_ptr    <= r_rd_ptr + PW'(1);
              r_count     <= r_count - PW'(1);
            end
          end
        end
        default: begin
          r_state        <= ST_FILL;
          r_sample_ready <= 1'b1;
          r_read_valid   <= 1'b0;
          r_wr_ptr       <= '0;
          r_rd_ptr       <= '0;
          r_count        <= '0;
        end
      endcase
    end
  end

  // Dropped-sample accounting: sticky flag plus saturating counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != 8'hFF) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  assign sample_ready_o     = r_sample_ready;
  assign ram_read_data_o    = r_read_data;
  assign ram_read_valid_o   = r_read_valid;
  assign ram_buffer_ready_o = r_buf_ready;
  assign overflow_o         = r_overflow;
  assign drop_count_o       = r_drop_count;
  assign debug_o            = {r_state, r_buf_ready, w_rd_hs, r_count[1:0]};

endmodule

// File: tb/tb_audio_sample_buffer.sv
// Randomized bench for audio_sample_buffer against a queue-based block model.
module tb_audio_sample_buffer;

  localparam int D = 16;
  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [W-1:0] sample_data_i;
  logic         sample_valid_i;
  logic         sample_ready_o;
  logic [W-1:0] ram_read_data_o;
  logic         ram_read_valid_o;
  logic         ram_read_ready_i;
  logic         ram_buffer_ready_o;
  logic         overflow_o;
  logic [7:0]   drop_count_o;
  logic [5:0]   debug_o;

  always #5 clk = ~clk;

  audio_sample_buffer #(.BUFFER_DEPTH(D), .DATA_WIDTH(W)) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .sample_data_i      (sample_data_i),
    .sample_valid_i     (sample_valid_i),
    .sample_ready_o     (sample_ready_o),
    .ram_read_data_o    (ram_read_data_o),
    .ram_read_valid_o   (ram_read_valid_o),
    .ram_read_ready_i   (ram_read_ready_i),
    .ram_buffer_ready_o (ram_buffer_ready_o),
    .overflow_o         (overflow_o),
    .drop_count_o       (drop_count_o),
    .debug_o            (debug_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: samples collected for the block, samples still owed to the consumer
  logic [W-1:0] m_fill[$];
  logic [W-1:0] m_out[$];
  bit           m_ann  = 1'b0;
  int           m_drops = 0;
  bit           m_ovf  = 1'b0;
  logic [W-1:0] m_last = '0;

  function automatic bit m_rdy();
    return !m_ann && (m_out.size() == 0);
  endfunction

  task automatic check_outputs();
    bit           ev;
    logic [W-1:0] ed;
    int           st;
    int           cnt;
    ev  = (m_out.size() > 0);
    ed  = ev ? m_out[0] : m_last;
    st  = m_ann ? 1 : (ev ? 2 : 0);
    cnt = ev ? m_out.size() : (m_ann ? D : m_fill.size());
    check_eq("sample_ready", 32'(sample_ready_o), 32'(m_rdy()));
    check_eq("buffer_ready", 32'(ram_buffer_ready_o), 32'(m_ann));
    check_eq("read_valid", 32'(ram_read_valid_o), 32'(ev));
    check_eq("read_data", 32'(ram_read_data_o), 32'(ed));
    check_eq("overflow", 32'(overflow_o), 32'(m_ovf));
    check_eq("drop_count", 32'(drop_count_o), 32'((m_drops > 255) ? 255 : m_drops));
    check_eq("dbg_state", 32'(debug_o[5:4]), 32'(st));
    check_eq("dbg_pulse", 32'(debug_o[3]), 32'(m_ann));
    check_eq("dbg_hs", 32'(debug_o[2]), 32'(ev && ram_read_ready_i));
    check_eq("dbg_count", 32'(debug_o[1:0]), 32'(cnt % 4));
  endtask

  task automatic model_update(input bit v, input logic [W-1:0] d, input bit r, input bit rs);
    if (rs) begin
      m_fill.delete(); m_out.delete();
      m_ann = 1'b0; m_drops = 0; m_ovf = 1'b0; m_last = '0;
    end else if (m_ann) begin
      if (v) begin m_drops++; m_ovf = 1'b1; end
      m_out = m_fill;
      m_fill.delete();
      m_ann = 1'b0;
    end else if (m_out.size() > 0) begin
      if (v) begin m_drops++; m_ovf = 1'b1; end
      if (r) m_last = m_out.pop_front();
    end else if (v) begin
      m_fill.push_back(d);
      if (m_fill.size() == D) m_ann = 1'b1;
    end
  endtask

  // One clock: drive at negedge, check, then advance the model on the rising edge
  task automatic cyc(input bit v, input logic [W-1:0] d, input bit r, input bit rs);
    @(negedge clk);
    sample_valid_i   = v;
    sample_data_i    = d;
    ram_read_ready_i = r;
    rst_i            = rs;
    #1;
    check_outputs();
    @(posedge clk);
    model_update(v, d, r, rs);
  endtask

  // mode 0: dense random, 1: valid on alternate cycles, 2: includes full-scale values
  task automatic fill_block(input int mode);
    int n = 0;
    for (int k = 0; k < 4 * D && !m_ann; k++) begin
      logic [W-1:0] d;
      bit v;
      d = W'($urandom);
      v = (mode == 1) ? (k % 2 == 0) : 1'b1;
      if (mode == 2 && n == 3) d = 24'h800000;
      if (mode == 2 && n == 7) d = 24'hFFFFFF;
      if (mode == 2 && n == 0) d = 24'h7FFFFF;
      if (v) n++;
      cyc(v, d, 1'($urandom), 1'b0);
    end
    if (!m_ann) begin
      n_checks++;
      $display("FAIL fill_timeout: got %0d samples required %0d", m_fill.size(), D);
    end
  endtask

  // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic drain_block(input int mode);
    bit pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int k = 0; k < 8 * D && (m_ann || m_out.size() > 0); k++) begin
      bit r;
      r = (mode == 0) ? 1'b1 : (mode == 1) ? pat[k % 4] : 1'($urandom);
      cyc(1'b0, W'($urandom), r, 1'b0);
    end
    if (m_ann || m_out.size() > 0) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d samples left required 0", m_out.size());
    end
  endtask

  initial begin
    rst_i = 1'b1; sample_valid_i = 1'b0; sample_data_i = '0; ram_read_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // basic transfer: 1..16 with valid and ready held high
    for (int i = 1; i <= D; i++) cyc(1'b1, W'(i), 1'b1, 1'b0);
    repeat (D + 3) cyc(1'b0, '0, 1'b1, 1'b0);

    // backpressure during drain
    fill_block(0);
    drain_block(1);

    // negative full scale and sign-bit patterns
    fill_block(2);
    drain_block(2);

    // overflow: 20 drops from drain entry, then saturation
    cyc(1'b0, '0, 1'b0, 1'b1);
    fill_block(0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    repeat (20) cyc(1'b1, W'($urandom), 1'b0, 1'b0);
    #2;
    check_eq("drop20_count", 32'(drop_count_o), 32'd20);
    check_eq("drop20_flag", 32'(overflow_o), 32'd1);
    drain_block(0);
    fill_block(0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    repeat (300) cyc(1'b1, W'($urandom), 1'b0, 1'b0);
    #2;
    check_eq("drop_saturate", 32'(drop_count_o), 32'd255);
    drain_block(0);

    // reset after the fifth drain handshake
    fill_block(0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    repeat (5) cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    #2;
    check_eq("rst_mid_valid", 32'(ram_read_valid_o), 32'd0);
    check_eq("rst_mid_state", 32'(debug_o[5:4]), 32'd0);
    check_eq("rst_mid_ready", 32'(sample_ready_o), 32'd1);
    fill_block(0);
    drain_block(0);

    // gapped input
    fill_block(1);
    drain_block(2);

    // fully random traffic with occasional resets
    for (int k = 0; k < 800; k++) begin
      cyc(1'($urandom_range(0, 2) != 0), W'($urandom), 1'($urandom),
          ($urandom_range(0, 150) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
